// File: rtl/hwpe_ctrl_job_dispatcher_pkg.sv
// HWPE control: shared register map, response codes, FSM states and
// the register-file access/flag bundles used by the job dispatcher.
package hwpe_ctrl_package;

  localparam int unsigned REGFILE_N_CONTEXT  = 2;
  localparam int unsigned N_MANDATORY_REGS   = 7;
  localparam int unsigned N_RESERVED_REGS    = 1;
  localparam int unsigned N_MAX_GENERIC_REGS = 8;
  localparam int unsigned LOG_REGS           = 5;
  localparam int unsigned LOG_MAX_CONTEXT    = 2;
  localparam int unsigned CTX_BASE =
    N_MANDATORY_REGS + N_RESERVED_REGS + N_MAX_GENERIC_REGS;

  localparam logic [LOG_REGS-1:0] REG_TRIGGER     = 5'd0;
  localparam logic [LOG_REGS-1:0] REG_ACQUIRE     = 5'd1;
  localparam logic [LOG_REGS-1:0] REG_FINISHED    = 5'd2;
  localparam logic [LOG_REGS-1:0] REG_STATUS      = 5'd3;
  localparam logic [LOG_REGS-1:0] REG_RUNNING_JOB = 5'd4;
  localparam logic [LOG_REGS-1:0] REG_SOFTCLEAR   = 5'd5;
  localparam logic [LOG_REGS-1:0] REG_EXT         = 5'd6;

  localparam logic [31:0] RESP_FULL   = 32'hFFFF_FFFF;
  localparam logic [31:0] RESP_LOCKED = 32'hFFFF_FFFE;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef struct packed {
    logic [LOG_MAX_CONTEXT+LOG_REGS-1:0] addr;
    logic [31:0]                         wdata;
    logic [3:0]                          be;
    logic                                wren;
    logic [15:0]                         src;
  } regfile_in_t;

  typedef struct packed {
    logic [31:0] rdata;
  } regfile_out_t;

  typedef struct packed {
    logic                       is_mandatory;
    logic                       is_contexted;
    logic                       is_read;
    logic                       is_testset;
    logic                       is_trigger;
    logic                       is_critical;
    logic                       full_context;
    logic [LOG_MAX_CONTEXT-1:0] pointer_context;
    logic [LOG_MAX_CONTEXT-1:0] running_context;
    logic                       true_done;
    logic                       ext_re;
    logic                       ext_we;
  } flags_regfile_t;

endpackage

// File: rtl/hwpe_ctrl_job_queue.sv
// HWPE job queue: queued-context counter, program/run pointers and
// the engine launch FSM (IDLE -> START -> RUN).
module hwpe_ctrl_job_queue
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned CW        = 1,
  parameter int unsigned QW        = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear,
  input  logic          push,
  input  logic          done,
  output logic [CW-1:0] ptr,
  output logic [CW-1:0] run_ptr,
  output logic          full,
  output logic          start,
  output logic          busy,
  output logic          true_done
);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [QW-1:0] queued_q;

  function automatic logic [CW-1:0] wrap_inc(
    input logic [CW-1:0] p
  );
    return (p == CW'(N_CONTEXT-1)) ? '0 : p + 1'b1;
  endfunction

  assign true_done = (state_q == ST_RUN) & done;
  assign start     = (state_q == ST_START);
  assign full      = (queued_q == QW'(N_CONTEXT));
  assign busy      = (state_q != ST_IDLE) | (queued_q != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (queued_q != '0) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      queued_q <= '0;
      ptr      <= '0;
      run_ptr  <= '0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      queued_q <= '0;
      ptr      <= '0;
      run_ptr  <= '0;
    end else begin
      state_q  <= state_d;
      queued_q <= queued_q + QW'(push) - QW'(true_done);
      if (push)      ptr     <= wrap_inc(ptr);
      if (true_done) run_ptr <= wrap_inc(run_ptr);
    end
  end

endmodule

// File: rtl/hwpe_ctrl_job_dispatcher.sv
// HWPE job dispatcher: peripheral decode, acquire/trigger lock and
// launch of queued job contexts on the engine.
module hwpe_ctrl_job_dispatcher
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_CONTEXT      = REGFILE_N_CONTEXT,
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned N_IO_REGS      = 2,
  parameter int unsigned N_GENERIC_REGS = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         data_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                r_valid_o,
  output logic [31:0]         r_data_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output regfile_in_t         regfile_in_o,
  input  regfile_out_t        regfile_out_i,
  output flags_regfile_t      flags_o,
  output logic                clear_o,
  output logic                start_o,
  input  logic                done_i,
  output logic                busy_o,
  output logic                evt_o
);

  localparam int unsigned CW =
    (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int unsigned QW = $clog2(N_CONTEXT) + 1;

  logic [LOG_REGS-1:0]        idx;
  logic [LOG_MAX_CONTEXT-1:0] ctx_sel;
  logic                       rd, wr, ctx, own;
  logic                       acq_rd, trig_ok, sclr, drop;
  logic                       lock_q, rvalid_q, rread_q, clear_q;
  logic [ID_WIDTH-1:0]        owner_q, rid_q;
  logic [CW-1:0]              ptr, run_ptr;
  logic                       full, true_done;
  logic                       unused_cfg;

  assign unused_cfg = ^{add_i[31:LOG_REGS+2], add_i[1:0],
                        32'(N_IO_REGS), 32'(N_GENERIC_REGS)};

  assign idx     = add_i[LOG_REGS+1:2];
  assign rd      = req_i & wen_i;
  assign wr      = req_i & ~wen_i;
  assign ctx     = idx >= LOG_REGS'(CTX_BASE);
  assign own     = (id_i == owner_q);
  assign acq_rd  = rd & (idx == REG_ACQUIRE);
  assign trig_ok = wr & (idx == REG_TRIGGER) & lock_q & own;
  assign sclr    = wr & (idx == REG_SOFTCLEAR);
  // contexted writes from anyone but the lock owner are discarded
  assign drop    = wr & ctx & lock_q & ~own;
  assign ctx_sel = ctx ? LOG_MAX_CONTEXT'(ptr) : '0;

  assign gnt_o     = req_i;
  assign r_valid_o = rvalid_q;
  assign r_id_o    = rid_q;
  assign r_data_o  = rread_q ? regfile_out_i.rdata : '0;
  assign clear_o   = clear_q;
  assign evt_o     = true_done;

  always_comb begin
    regfile_in_o = '0;
    if (req_i) begin
      regfile_in_o.addr  = {ctx_sel, idx};
      regfile_in_o.wdata = data_i;
      regfile_in_o.be    = be_i;
      regfile_in_o.src   = 16'(id_i);
      regfile_in_o.wren  = wr & (idx != REG_TRIGGER)
                         & (idx != REG_SOFTCLEAR) & ~drop;
    end
  end

  always_comb begin
    flags_o = '0;
    flags_o.is_mandatory    = req_i
                            & (idx < LOG_REGS'(N_MANDATORY_REGS));
    flags_o.is_contexted    = req_i & ctx;
    flags_o.is_read         = rd;
    flags_o.is_testset      = acq_rd;
    flags_o.is_trigger      = trig_ok;
    flags_o.is_critical     = acq_rd & lock_q;
    flags_o.full_context    = full;
    flags_o.pointer_context = LOG_MAX_CONTEXT'(ptr);
    flags_o.running_context = LOG_MAX_CONTEXT'(run_ptr);
    flags_o.true_done       = true_done;
    flags_o.ext_re          = rd & (idx == REG_EXT);
    flags_o.ext_we          = wr & (idx == REG_EXT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (sclr) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (trig_ok) begin
      lock_q  <= 1'b0;
    end else if (acq_rd & ~lock_q & ~full) begin
      lock_q  <= 1'b1;
      owner_q <= id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rread_q  <= 1'b0;
      rid_q    <= '0;
      clear_q  <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rread_q  <= rd;
      clear_q  <= sclr;
      if (req_i) rid_q <= id_i;
    end
  end

  hwpe_ctrl_job_queue #(
    .N_CONTEXT (N_CONTEXT),
    .CW        (CW),
    .QW        (QW)
  ) i_queue (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (sclr),
    .push      (trig_ok),
    .done      (done_i),
    .ptr       (ptr),
    .run_ptr   (run_ptr),
    .full      (full),
    .start     (start_o),
    .busy      (busy_o),
    .true_done (true_done)
  );

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// Self-checking bench for hwpe_ctrl_job_dispatcher: directed protocol
// scenarios followed by a randomized run against a job/lock model.
module tb_hwpe_ctrl_job_dispatcher;
  import hwpe_ctrl_package::*;

  localparam int NC = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic           wen = 1'b1;
  logic [31:0]    add = '0;
  logic [31:0]    wdata = '0;
  logic [3:0]     be = '0;
  logic [15:0]    id = '0;
  logic           done = 1'b0;
  logic           gnt, r_valid, clear, start, busy, evt;
  logic [31:0]    r_data;
  logic [15:0]    r_id;
  regfile_in_t    rf_in;
  regfile_out_t   rf_out = '0;
  flags_regfile_t flags;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int evt_cnt = 0;

  flags_regfile_t s_f;
  regfile_in_t    s_rin;
  logic           s_gnt, s_rv, s_evt;
  logic [31:0]    s_rd;
  logic [15:0]    s_rid;

  always #5 clk = ~clk;

  hwpe_ctrl_job_dispatcher #(
    .N_CONTEXT      (NC),
    .ID_WIDTH       (16),
    .N_IO_REGS      (2),
    .N_GENERIC_REGS (0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .gnt_o         (gnt),
    .add_i         (add),
    .wen_i         (wen),
    .be_i          (be),
    .data_i        (wdata),
    .id_i          (id),
    .r_valid_o     (r_valid),
    .r_data_o      (r_data),
    .r_id_o        (r_id),
    .regfile_in_o  (rf_in),
    .regfile_out_i (rf_out),
    .flags_o       (flags),
    .clear_o       (clear),
    .start_o       (start),
    .done_i        (done),
    .busy_o        (busy),
    .evt_o         (evt)
  );

  // stand-in register file: answers the test-and-set, else echoes addr
  always @(posedge clk) begin
    if (flags.is_testset)
      rf_out.rdata <= flags.is_critical ? RESP_LOCKED :
                      flags.full_context ? RESP_FULL : 32'h0;
    else
      rf_out.rdata <= {16'hBEEF, 9'h0, rf_in.addr};
  end

  always @(negedge clk) begin
    if (start) start_cnt++;
    if (evt) evt_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input logic w, input logic [4:0] ix,
                        input logic [15:0] who, input logic [31:0] wd,
                        input logic dn);
    req = 1'b1; wen = ~w; add = {25'h0, ix, 2'b00};
    id = who; wdata = wd; be = 4'hF; done = dn;
    #3;
    s_f = flags; s_rin = rf_in; s_gnt = gnt; s_evt = evt;
    @(posedge clk);
    #1;
    req = 1'b0; done = 1'b0; wen = 1'b1;
    add = '0; wdata = '0; be = '0;
    s_rv = r_valid; s_rd = r_data; s_rid = r_id;
  endtask

  task automatic test_reset;
    total++;
    if ({gnt, r_valid, r_data, r_id} !== '0) begin
      bad++;
      $display("FAIL reset_bus got=%h exp=0", {gnt, r_valid, r_data, r_id});
    end
    total++;
    if ({rf_in, flags} !== '0) begin
      bad++;
      $display("FAIL reset_rf got=%h exp=0", {rf_in, flags});
    end
    total++;
    if ({clear, start, busy, evt} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {clear, start, busy, evt});
    end
  endtask

  task automatic test_acquire;
    access(1'b0, REG_ACQUIRE, 16'd3, 32'h0, 1'b0);
    total++;
    if ({s_gnt, s_f.is_testset, s_f.is_read, s_f.is_critical} !== 4'b1110) begin
      bad++;
      $display("FAIL acq_flags got=%b exp=1110",
               {s_gnt, s_f.is_testset, s_f.is_read, s_f.is_critical});
    end
    total++;
    if ({s_rv, s_rid} !== {1'b1, 16'd3}) begin
      bad++;
      $display("FAIL acq_resp got=%b/%0d exp=1/3", s_rv, s_rid);
    end
    total++;
    if (s_rd !== 32'h0) begin
      bad++;
      $display("FAIL acq_data got=%h exp=0", s_rd);
    end
  endtask

  task automatic test_contention;
    int s0;
    s0 = start_cnt;
    access(1'b0, REG_ACQUIRE, 16'd5, 32'h0, 1'b0);
    total++;
    if (s_f.is_critical !== 1'b1) begin
      bad++;
      $display("FAIL cont_critical got=%b exp=1", s_f.is_critical);
    end
    total++;
    if (s_rd !== RESP_LOCKED) begin
      bad++;
      $display("FAIL cont_data got=%h exp=%h", s_rd, RESP_LOCKED);
    end
    access(1'b1, REG_TRIGGER, 16'd5, 32'h0, 1'b0);
    total++;
    if ({s_f.is_trigger, s_rin.wren} !== 2'b00) begin
      bad++;
      $display("FAIL cont_trig got=%b exp=00", {s_f.is_trigger, s_rin.wren});
    end
    idle(4);
    total++;
    if ({busy, flags.pointer_context} !== 3'b000 || start_cnt != s0) begin
      bad++;
      $display("FAIL cont_noop busy=%b ptr=%0d starts=%0d exp=0/0/%0d",
               busy, flags.pointer_context, start_cnt, s0);
    end
  endtask

  task automatic test_trigger;
    int s0;
    s0 = start_cnt;
    access(1'b1, 5'd16, 16'd3, 32'h1111, 1'b0);
    total++;
    if ({s_rin.wren, s_rin.addr} !== {1'b1, 7'd16}) begin
      bad++;
      $display("FAIL trig_io0 got=%b/%h exp=1/10", s_rin.wren, s_rin.addr);
    end
    total++;
    if (s_rd !== 32'h0) begin
      bad++;
      $display("FAIL trig_wresp got=%h exp=0", s_rd);
    end
    access(1'b1, 5'd17, 16'd3, 32'h2222, 1'b0);
    total++;
    if ({s_rin.wren, s_rin.addr, s_rin.wdata} !== {1'b1, 7'd17, 32'h2222}) begin
      bad++;
      $display("FAIL trig_io1 got=%b/%h/%h exp=1/11/2222",
               s_rin.wren, s_rin.addr, s_rin.wdata);
    end
    access(1'b1, 5'd16, 16'd9, 32'h3333, 1'b0);
    total++;
    if (s_rin.wren !== 1'b0) begin
      bad++;
      $display("FAIL trig_drop got=%b exp=0", s_rin.wren);
    end
    access(1'b1, REG_TRIGGER, 16'd3, 32'h0, 1'b0);
    total++;
    if ({s_f.is_trigger, s_rin.wren} !== 2'b10) begin
      bad++;
      $display("FAIL trig_flag got=%b exp=10", {s_f.is_trigger, s_rin.wren});
    end
    #2;
    total++;
    if ({flags.pointer_context, busy, start} !== 4'b0110) begin
      bad++;
      $display("FAIL trig_t1 got=%b exp=0110",
               {flags.pointer_context, busy, start});
    end
    @(posedge clk);
    #3;
    total++;
    if (start !== 1'b1) begin
      bad++;
      $display("FAIL trig_t2_start got=%b exp=1", start);
    end
    @(posedge clk);
    #3;
    total++;
    if (start !== 1'b0 || start_cnt != s0 + 1) begin
      bad++;
      $display("FAIL trig_t3_start got=%b/%0d exp=0/%0d", start, start_cnt, s0 + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_done_trigger;
    int e0;
    e0 = evt_cnt;
    access(1'b0, REG_ACQUIRE, 16'd3, 32'h0, 1'b0);
    total++;
    if (s_rd !== 32'h0) begin
      bad++;
      $display("FAIL dt_acq got=%h exp=0", s_rd);
    end
    access(1'b1, 5'd16, 16'd3, 32'h4444, 1'b0);
    access(1'b1, REG_TRIGGER, 16'd3, 32'h0, 1'b1);
    total++;
    if ({s_f.is_trigger, s_f.true_done, s_evt} !== 3'b111) begin
      bad++;
      $display("FAIL dt_pulse got=%b exp=111",
               {s_f.is_trigger, s_f.true_done, s_evt});
    end
    total++;
    if ({flags.running_context, flags.pointer_context, flags.full_context, busy}
        !== 6'b01_00_0_1) begin
      bad++;
      $display("FAIL dt_after got=%b exp=010001",
               {flags.running_context, flags.pointer_context,
                flags.full_context, busy});
    end
    total++;
    if (evt_cnt != e0 + 1) begin
      bad++;
      $display("FAIL dt_evtcnt got=%0d exp=%0d", evt_cnt, e0 + 1);
    end
  endtask

  task automatic test_full;
    access(1'b0, REG_ACQUIRE, 16'd3, 32'h0, 1'b0);
    access(1'b1, REG_TRIGGER, 16'd3, 32'h0, 1'b0);
    total++;
    if ({flags.full_context, flags.pointer_context} !== 3'b101) begin
      bad++;
      $display("FAIL full_flag got=%b exp=101",
               {flags.full_context, flags.pointer_context});
    end
    access(1'b0, REG_ACQUIRE, 16'd7, 32'h0, 1'b0);
    total++;
    if ({s_f.is_critical, s_f.full_context} !== 2'b01) begin
      bad++;
      $display("FAIL full_acqflags got=%b exp=01",
               {s_f.is_critical, s_f.full_context});
    end
    total++;
    if (s_rd !== RESP_FULL) begin
      bad++;
      $display("FAIL full_acqdata got=%h exp=%h", s_rd, RESP_FULL);
    end
  endtask

  task automatic test_softclear;
    int s0, e0;
    access(1'b1, REG_SOFTCLEAR, 16'd9, 32'h0, 1'b0);
    total++;
    if (s_rin.wren !== 1'b0) begin
      bad++;
      $display("FAIL sc_wren got=%b exp=0", s_rin.wren);
    end
    total++;
    if ({clear, busy, flags.pointer_context, flags.running_context,
         flags.full_context} !== 7'b1_0_00_00_0) begin
      bad++;
      $display("FAIL sc_t1 got=%b exp=1000000",
               {clear, busy, flags.pointer_context, flags.running_context,
                flags.full_context});
    end
    idle(1);
    total++;
    if (clear !== 1'b0) begin
      bad++;
      $display("FAIL sc_t2 got=%b exp=0", clear);
    end
    s0 = start_cnt;
    e0 = evt_cnt;
    done = 1'b1;
    #3;
    total++;
    if (evt !== 1'b0) begin
      bad++;
      $display("FAIL sc_done_evt got=%b exp=0", evt);
    end
    @(posedge clk);
    #1;
    done = 1'b0;
    idle(3);
    total++;
    if (start_cnt != s0 || evt_cnt != e0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sc_quiet got=%0d/%0d/%b exp=%0d/%0d/0",
               start_cnt, evt_cnt, busy, s0, e0);
    end
    access(1'b0, REG_ACQUIRE, 16'd4, 32'h0, 1'b0);
    total++;
    if ({s_f.is_critical, s_rd} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL sc_lockfree got=%b/%h exp=0/0", s_f.is_critical, s_rd);
    end
  endtask

  task automatic test_random;
    bit m_lock;
    int m_owner, m_q, m_ptr, m_run, ndone, s0;
    access(1'b1, REG_SOFTCLEAR, 16'd0, 32'h0, 1'b0);
    idle(2);
    m_lock = 0; m_owner = 0; m_q = 0; m_ptr = 0; m_run = 0; ndone = 0;
    s0 = start_cnt;
    for (int i = 0; i < 150; i++) begin
      int op, who, ix;
      logic [31:0] exp_d;
      bit exp_b;
      op = int'($urandom_range(0, 4));
      who = int'($urandom_range(0, 3));
      case (op)
        0: begin
          exp_d = m_lock ? RESP_LOCKED : (m_q == NC) ? RESP_FULL : 32'h0;
          access(1'b0, REG_ACQUIRE, 16'(who), 32'h0, 1'b0);
          total++;
          if (s_rd !== exp_d || s_f.is_critical !== m_lock) begin
            bad++;
            $display("FAIL rnd_acq it=%0d got=%h/%b exp=%h/%b",
                     i, s_rd, s_f.is_critical, exp_d, m_lock);
          end
          if (!m_lock && m_q < NC) begin
            m_lock = 1; m_owner = who;
          end
        end
        1: begin
          exp_b = m_lock && who == m_owner;
          access(1'b1, REG_TRIGGER, 16'(who), 32'h0, 1'b0);
          total++;
          if (s_f.is_trigger !== exp_b) begin
            bad++;
            $display("FAIL rnd_trig it=%0d got=%b exp=%b", i, s_f.is_trigger, exp_b);
          end
          if (exp_b) begin
            m_lock = 0; m_ptr = (m_ptr + 1) % NC; m_q++;
          end
        end
        2: begin
          ix = 16 + int'($urandom_range(0, 1));
          exp_b = !(m_lock && who != m_owner);
          access(1'b1, 5'(ix), 16'(who), $urandom, 1'b0);
          total++;
          if (s_rin.wren !== exp_b || s_rin.addr !== {2'(m_ptr), 5'(ix)}) begin
            bad++;
            $display("FAIL rnd_io it=%0d got=%b/%h exp=%b/%h",
                     i, s_rin.wren, s_rin.addr, exp_b, {2'(m_ptr), 5'(ix)});
          end
        end
        3: begin
          idle(3);
          done = 1'b1;
          #3;
          total++;
          if (evt !== (m_q > 0)) begin
            bad++;
            $display("FAIL rnd_done it=%0d got=%b exp=%b", i, evt, m_q > 0);
          end
          @(posedge clk);
          #1;
          done = 1'b0;
          if (m_q > 0) begin
            m_q--; m_run = (m_run + 1) % NC; ndone++;
          end
        end
        default: begin
          idle(1);
          total++;
          if (busy !== (m_q != 0) || flags.pointer_context !== 2'(m_ptr)
              || flags.running_context !== 2'(m_run)
              || flags.full_context !== (m_q == NC)) begin
            bad++;
            $display("FAIL rnd_state it=%0d got=%b/%0d/%0d/%b exp=%b/%0d/%0d/%b",
                     i, busy, flags.pointer_context, flags.running_context,
                     flags.full_context, m_q != 0, m_ptr, m_run, m_q == NC);
          end
        end
      endcase
    end
    idle(4);
    total++;
    if (start_cnt - s0 != ndone + (m_q > 0 ? 1 : 0)) begin
      bad++;
      $display("FAIL rnd_starts got=%0d exp=%0d",
               start_cnt - s0, ndone + (m_q > 0 ? 1 : 0));
    end
  endtask

  task automatic test_reset_midjob;
    int s0, e0;
    access(1'b1, REG_SOFTCLEAR, 16'd0, 32'h0, 1'b0);
    idle(2);
    access(1'b0, REG_ACQUIRE, 16'd2, 32'h0, 1'b0);
    access(1'b1, REG_TRIGGER, 16'd2, 32'h0, 1'b0);
    idle(4);
    rst_n = 1'b0;
    idle(1);
    total++;
    if ({busy, start, r_valid, clear} !== 4'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b exp=0000", {busy, start, r_valid, clear});
    end
    rst_n = 1'b1;
    s0 = start_cnt;
    e0 = evt_cnt;
    done = 1'b1;
    #3;
    total++;
    if (evt !== 1'b0) begin
      bad++;
      $display("FAIL rst_done_evt got=%b exp=0", evt);
    end
    @(posedge clk);
    #1;
    done = 1'b0;
    idle(3);
    total++;
    if (evt_cnt != e0 || start_cnt != s0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_quiet got=%0d/%0d/%b exp=%0d/%0d/0",
               evt_cnt, start_cnt, busy, e0, s0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    idle(1);
    test_acquire;
    test_contention;
    test_trigger;
    test_done_trigger;
    test_full;
    test_softclear;
    test_random;
    test_reset_midjob;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
